ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 156 +++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode decoder.
// Takes the bytes coming out of the PS/2 receiver and turns make/break/extended
// sequences into single key events in a small first-word-fall-through queue.
// It also flags the keyboard's self-test and error responses.
//
// Ports:
//   clk, reset           system clock; asynchronous active-high reset
//   received_data[7:0]   byte from the receiver, valid while received_data_en=1
//   received_data_en     one-cycle strobe marking a new byte
//   key_ready            consumer accepts the head event
//   clear_status         pulse that clears overflow, bat_ok and kbd_error
//   key_valid            queue non-empty; head event presented
//   key_code[7:0]        head event base code
//   key_extended         head event was E0-prefixed, or is the Pause event
//   key_released         head event was a break (F0-prefixed)
//   overflow             sticky; an event was dropped because the queue was full
//   bat_ok               sticky; 0xAA seen in IDLE
//   kbd_error            sticky; 0xFC, 0x00 or 0xFF seen in IDLE
//
// Decoder states:
//   IDLE       | no prefix pending
//   PFX_E0     | extended prefix seen
//   PFX_F0     | break prefix seen
//   PFX_E0F0   | extended break prefix seen
//   PAUSE_SKIP | swallowing the rest of the Pause sequence
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       key_ready,
  input  logic       clear_status,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       overflow,
  output logic       bat_ok,
  output logic       kbd_error
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, PFX_E0, PFX_F0, PFX_E0F0, PAUSE_SKIP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  skip_cnt, skip_cnt_nxt;
  logic        push_req;
  logic [9:0]  push_data;
  logic        bat_set, err_set;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, pop, do_push;

  // Byte decode. A prefix byte arriving in a break state restarts decoding
  // as if it had arrived in IDLE, so the stale prefix is discarded.
  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    push_req     = 1'b0;
    push_data    = 10'd0;
    bat_set      = 1'b0;
    err_set      = 1'b0;
    if (received_data_en) begin
      unique case (state)
        PFX_E0: begin
          if (received_data == 8'hF0) state_nxt = PFX_E0F0;
          else if (received_data != 8'hE0) begin
            push_req  = 1'b1;
            push_data = {2'b10, received_data};
            state_nxt = IDLE;
          end
        end
        PAUSE_SKIP: begin
          skip_cnt_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            push_req  = 1'b1;
            push_data = {2'b10, 8'hE1};
            state_nxt = IDLE;
          end
        end
        default: begin
          if (received_data == 8'hE0) state_nxt = PFX_E0;
          else if (received_data == 8'hF0) state_nxt = PFX_F0;
          else if (received_data == 8'hE1) begin
            state_nxt    = PAUSE_SKIP;
            skip_cnt_nxt = 3'd7;
          end else if (state == PFX_F0) begin
            push_req  = 1'b1;
            push_data = {2'b01, received_data};
            state_nxt = IDLE;
          end else if (state == PFX_E0F0) begin
            push_req  = 1'b1;
            push_data = {2'b11, received_data};
            state_nxt = IDLE;
          end else if (received_data == 8'hAA) bat_set = 1'b1;
          else if (received_data == 8'hFC || received_data == 8'h00 ||
                   received_data == 8'hFF) err_set = 1'b1;
          else if (received_data != 8'hFA) begin
            push_req  = 1'b1;
            push_data = {2'b00, received_data};
          end
        end
      endcase
    end
  end

  assign full      = (count == FULL_CNT);
  assign key_valid = (count != '0);
  assign pop       = key_valid & key_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push   = push_req & (~full | pop);

  assign key_extended = mem[rd_ptr][9];
  assign key_released = mem[rd_ptr][8];
  assign key_code     = mem[rd_ptr][7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      skip_cnt  <= 3'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bat_ok    <= 1'b0;
      kbd_error <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 10'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !do_push) count <= count - (AW+1)'(1);
      // Set takes priority over clear.
      if (push_req && !do_push) overflow <= 1'b1;
      else if (clear_status)    overflow <= 1'b0;
      if (bat_set)           bat_ok <= 1'b1;
      else if (clear_status) bat_ok <= 1'b0;
      if (err_set)           kbd_error <= 1'b1;
      else if (clear_status) kbd_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder (FIFO_DEPTH=4).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       key_ready = 1'b0;
  logic       clear_status = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       overflow;
  logic       bat_ok;
  logic       kbd_error;

  int checks = 0;
  int failures = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .key_ready(key_ready),
    .clear_status(clear_status),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_extended(key_extended),
    .key_released(key_released),
    .overflow(overflow),
    .bat_ok(bat_ok),
    .kbd_error(kbd_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Head event packed as {valid, ext, rel, code}.
  function automatic logic [31:0] head();
    return {21'd0, key_valid, key_extended, key_released, key_code};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_head", head(), 32'h000);
    chk("reset_status", {29'd0, overflow, bat_ok, kbd_error}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // make then break
    send(8'h1C);
    chk("make_1c", head(), 32'h41C);
    pop_one();
    chk("make_popped", head() >> 11, 32'h0);
    send(8'hF0);
    chk("f0_no_event", {31'd0, key_valid}, 32'h0);
    send(8'h1C);
    chk("break_1c", head(), 32'h51C);
    pop_one();

    // extended make / extended break
    send(8'hE0); send(8'h75);
    chk("ext_make_75", head(), 32'h675);
    pop_one();
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break_75", head(), 32'h775);
    pop_one();

    // break prefix discarded by a fresh E0
    send(8'hF0); send(8'hE0); send(8'h75);
    chk("f0_e0_restart", head(), 32'h675);
    pop_one();

    // Pause: one event only
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_inner_none", {31'd0, key_valid}, 32'h0);
    send(8'h77);
    chk("pause_event", head(), 32'h6E1);
    pop_one();
    chk("pause_single", {31'd0, key_valid}, 32'h0);

    // overflow
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    chk("full_no_ovf", {31'd0, overflow}, 32'h0);
    send(8'h2C);
    chk("ovf_set", {31'd0, overflow}, 32'h1);
    chk("full_head", head(), 32'h415);
    // push and pop together while full
    @(negedge clk);
    received_data = 8'h1C; received_data_en = 1'b1; key_ready = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0; key_ready = 1'b0;
    chk("pp_head_1d", head(), 32'h41D);
    pop_one(); chk("pp_head_24", head(), 32'h424);
    pop_one(); chk("pp_head_2d", head(), 32'h42D);
    pop_one(); chk("pp_head_1c", head(), 32'h41C);
    pop_one(); chk("pp_empty", {31'd0, key_valid}, 32'h0);
    chk("ovf_sticky", {31'd0, overflow}, 32'h1);
    pulse_clear();
    chk("ovf_cleared", {31'd0, overflow}, 32'h0);

    // status bytes
    send(8'hAA); send(8'hFA); send(8'hFC);
    chk("status_set", {30'd0, bat_ok, kbd_error}, 32'h3);
    chk("status_no_event", {31'd0, key_valid}, 32'h0);
    pulse_clear();
    chk("status_cleared", {30'd0, bat_ok, kbd_error}, 32'h0);
    // set wins over clear
    @(negedge clk);
    received_data = 8'hAA; received_data_en = 1'b1; clear_status = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0; clear_status = 1'b0;
    chk("set_wins", {31'd0, bat_ok}, 32'h1);

    // reset mid-sequence with a queued event
    send(8'h33);
    chk("pre_reset_q", head(), 32'h433);
    send(8'hE0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_head", head(), 32'h000);
    chk("async_reset_bat", {31'd0, bat_ok}, 32'h0);
    #1 reset = 1'b0;
    send(8'h1C);
    chk("post_reset_1c", head(), 32'h41C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
